// File: rtl/fifo_from_sdram_rd_serializer_if.sv
// rtl/fifo_from_sdram_rd_serializer_if.sv - FIFO read port and byte-stream bundle for the readback serializer
interface fifo_from_sdram_rd_serializer_if #(
    parameter int DATA_W  = 16,
    parameter int USEDW_W = 10
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [USEDW_W-1:0] usedw;
    logic [DATA_W-1:0]  fifo_q;
    logic               rdreq;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               byte_ready;
    logic [IDX_W-1:0]   byte_idx;
    logic               last_byte;

    modport master (
        input  usedw, fifo_q, byte_ready,
        output rdreq, byte_out, byte_valid, byte_idx, last_byte
    );

    modport slave (
        output usedw, fifo_q, byte_ready,
        input  rdreq, byte_out, byte_valid, byte_idx, last_byte
    );
endinterface

// File: rtl/fifo_from_sdram_rd_serializer.sv
// rtl/fifo_from_sdram_rd_serializer.sv - FIFO word to byte-stream serializer with prefetch; RD_SER_STATS_EN adds word_cnt/stall_pulse
module fifo_from_sdram_rd_serializer #(
    parameter int DATA_W     = 16,
    parameter int USEDW_W    = 10,
    parameter int RD_LATENCY = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic clk,
    input  logic rst,
    fifo_from_sdram_rd_serializer_if.master sif,
    output logic busy
`ifdef RD_SER_STATS_EN
    ,
    output logic [31:0] word_cnt,
    output logic        stall_pulse
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [RD_LATENCY-1:0] inflight;
    logic                  rdreq_q;
    logic                  pf_full;
    logic                  sh_full;
    logic [DATA_W-1:0]     pf_word;
    logic [DATA_W-1:0]     sh_word;
    logic [IDX_W-1:0]      idx;
    logic [7:0]            byte_r;
    logic                  last_r;

    logic                  cap;
    logic                  xfer;
    logic                  last_xfer;
    logic                  sh_free;
    logic                  load_pf;
    logic                  load_byp;
    logic                  load;
    logic                  cap_to_pf;
    logic [DATA_W-1:0]     load_word;
    logic [IDX_W-1:0]      idx_nxt;

    function automatic logic [7:0] pick(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
        int k;
        k = (MSB_FIRST != 0) ? (NB - 1 - int'(i)) : int'(i);
        return w[8*k +: 8];
    endfunction

    assign cap       = inflight[RD_LATENCY-1];
    assign xfer      = sh_full & sif.byte_ready;
    assign last_xfer = xfer & (idx == LAST_IDX);
    assign sh_free   = ~sh_full | last_xfer;
    assign load_pf   = pf_full & sh_free;
    // A word landing while the prefetch is empty and the shifter is free goes straight in.
    assign load_byp  = cap & ~pf_full & sh_free;
    assign load      = load_pf | load_byp;
    assign cap_to_pf = cap & ~load_byp;
    assign load_word = pf_full ? pf_word : sif.fifo_q;
    assign idx_nxt   = idx + IDX_W'(1);

    // rdreq_q hides the one-clock lag of usedw after a read.
    assign sif.rdreq = ~rst & (sif.usedw != '0) & ~(|inflight) & ~pf_full & ~rdreq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            rdreq_q  <= 1'b0;
            pf_full  <= 1'b0;
            pf_word  <= '0;
            sh_full  <= 1'b0;
            sh_word  <= '0;
            idx      <= '0;
            byte_r   <= '0;
            last_r   <= 1'b0;
        end else begin
            rdreq_q  <= sif.rdreq;
            inflight <= (inflight << 1) | RD_LATENCY'(sif.rdreq);
            pf_full  <= cap_to_pf | (pf_full & ~load_pf);
            if (cap_to_pf) begin
                pf_word <= sif.fifo_q;
            end
            if (load) begin
                sh_full <= 1'b1;
                sh_word <= load_word;
                idx     <= '0;
                byte_r  <= pick(load_word, '0);
                last_r  <= (NB == 1);
            end else if (last_xfer) begin
                sh_full <= 1'b0;
                idx     <= '0;
                byte_r  <= '0;
                last_r  <= 1'b0;
            end else if (xfer) begin
                idx     <= idx_nxt;
                byte_r  <= pick(sh_word, idx_nxt);
                last_r  <= (idx_nxt == LAST_IDX);
            end
        end
    end

    assign sif.byte_out   = byte_r;
    assign sif.byte_valid = sh_full;
    assign sif.byte_idx   = idx;
    assign sif.last_byte  = last_r;
    assign busy           = (|inflight) | pf_full | sh_full;

`ifdef RD_SER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt    <= '0;
            stall_pulse <= 1'b0;
        end else begin
            if (last_xfer) begin
                word_cnt <= word_cnt + 32'd1;
            end
            stall_pulse <= sh_full & ~sif.byte_ready;
        end
    end
`endif
endmodule
